led_scan_sequencer: RTL and testbench

//  Parametrised scan/timing generator for the LED cube panel chains. Sequences load, serial shift,

---
 rtl/led_scan_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_led_scan_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_sequencer.sv
// Scan/timing generator for LED cube panel chains: per (row, PWM step) slot it sequences
// load, serial shift, blanking, latch and display, plus on-demand brightness-load cycles.
module led_scan_sequencer #(
    parameter int unsigned NUM_ROWS       = 16,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned SHIFT_LEN      = 16,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned DISPLAY_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        bright_req,
    output logic                        bright_ack,
    output logic                        sclk,
    output logic                        latch_enable,
    output logic                        output_enable_n,
    output logic                        shift,
    output logic                        load_led_vals,
    output logic                        load_brightness,
    output logic [NUM_ROWS-1:0]         row_select_n,
    output logic [$clog2(NUM_ROWS)-1:0] row_addr,
    output logic [PWM_BITS-1:0]         pwm_step,
    output logic                        frame_done
);

    localparam int unsigned ROW_W     = $clog2(NUM_ROWS);
    localparam int unsigned SHIFT_CYC = 2 * SHIFT_LEN;
    localparam int unsigned MAX_A     = (SHIFT_CYC > BLANK_CYCLES) ? SHIFT_CYC : BLANK_CYCLES;
    localparam int unsigned MAX_CYC   = (MAX_A > DISPLAY_CYCLES) ? MAX_A : DISPLAY_CYCLES;
    localparam int unsigned CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]    SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DISP_LAST  = CNT_W'(DISPLAY_CYCLES - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(NUM_ROWS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = '1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY,
        B_LOAD,
        B_SHIFT,
        B_LATCH
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [ROW_W-1:0]    row_d;
    logic [PWM_BITS-1:0] pwm_d;

    logic                frame_end_c;
    logic                ack_d;
    logic                sclk_d;
    logic                latch_d;
    logic                oe_n_d;
    logic                shift_d;
    logic                load_led_d;
    logic                load_bri_d;
    logic                frame_done_d;
    logic [NUM_ROWS-1:0] rsel_d;

    assign frame_end_c = (row_addr == ROW_LAST) && (pwm_step == PWM_LAST);

    // State and slot counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_addr <= '0;
            pwm_step <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_addr <= row_d;
            pwm_step <= pwm_d;
        end
    end

    // Next state; row/pwm only move on the last DISPLAY cycle, so they are stable per slot
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_addr;
        pwm_d   = pwm_step;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                row_d = '0;
                pwm_d = '0;
                if (enable) begin
                    state_d = bright_req ? B_LOAD : LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT, B_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = (state_q == SHIFT) ? BLANK : B_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                state_d = DISPLAY;
                cnt_d   = '0;
            end
            DISPLAY: begin
                if (cnt_q == DISP_LAST) begin
                    cnt_d = '0;
                    pwm_d = pwm_step + PWM_BITS'(1);
                    if (pwm_step == PWM_LAST) begin
                        row_d = (row_addr == ROW_LAST) ? '0 : row_addr + ROW_W'(1);
                    end
                    // enable=0 wins; a pending bright_req stays for the next enable
                    if (!enable) begin
                        state_d = IDLE;
                        row_d   = '0;
                        pwm_d   = '0;
                    end else if (bright_req && frame_end_c) begin
                        state_d = B_LOAD;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_LOAD: begin
                state_d = B_SHIFT;
                cnt_d   = '0;
            end
            B_LATCH: begin
                cnt_d   = '0;
                row_d   = '0;
                pwm_d   = '0;
                state_d = enable ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                row_d   = '0;
                pwm_d   = '0;
            end
        endcase
    end

    // Output decode from next state so registered outputs line up with the state they describe
    always_comb begin
        ack_d        = 1'b0;
        sclk_d       = 1'b0;
        latch_d      = 1'b0;
        oe_n_d       = 1'b1;
        shift_d      = 1'b0;
        load_led_d   = 1'b0;
        load_bri_d   = 1'b0;
        frame_done_d = 1'b0;
        rsel_d       = '1;
        unique case (state_d)
            LOAD:    load_led_d = 1'b1;
            B_LOAD:  load_bri_d = 1'b1;
            SHIFT, B_SHIFT: begin
                sclk_d  = cnt_d[0];
                shift_d = cnt_d[0];
            end
            LATCH: begin
                latch_d = 1'b1;
                for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                    if (row_d == ROW_W'(i)) rsel_d[i] = 1'b0;
                end
            end
            DISPLAY: begin
                oe_n_d       = 1'b0;
                frame_done_d = (cnt_d == DISP_LAST) && (row_d == ROW_LAST) && (pwm_d == PWM_LAST);
                for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                    if (row_d == ROW_W'(i)) rsel_d[i] = 1'b0;
                end
            end
            B_LATCH: begin
                latch_d = 1'b1;
                ack_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bright_ack      <= 1'b0;
            sclk            <= 1'b0;
            latch_enable    <= 1'b0;
            output_enable_n <= 1'b1;
            shift           <= 1'b0;
            load_led_vals   <= 1'b0;
            load_brightness <= 1'b0;
            frame_done      <= 1'b0;
            row_select_n    <= '1;
        end else begin
            bright_ack      <= ack_d;
            sclk            <= sclk_d;
            latch_enable    <= latch_d;
            output_enable_n <= oe_n_d;
            shift           <= shift_d;
            load_led_vals   <= load_led_d;
            load_brightness <= load_bri_d;
            frame_done      <= frame_done_d;
            row_select_n    <= rsel_d;
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed output events, a monitor pops and compares
// each event the DUT presents (load, shift pulse, latch, ack, display start, frame_done, probes).
module tb_led_scan_sequencer;

    localparam int unsigned NR = 2;
    localparam int unsigned PB = 1;

    localparam logic [2:0] K_LOAD  = 3'd0;
    localparam logic [2:0] K_BLOAD = 3'd1;
    localparam logic [2:0] K_SHIFT = 3'd2;
    localparam logic [2:0] K_LATCH = 3'd3;
    localparam logic [2:0] K_ACK   = 3'd4;
    localparam logic [2:0] K_DISP  = 3'd5;
    localparam logic [2:0] K_FRAME = 3'd6;
    localparam logic [2:0] K_PROBE = 3'd7;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic        row;
        logic        pwm;
        logic [1:0]  rsel;
        logic        oe_n;
        logic [6:0]  misc;  // sclk, latch, shift, load_led, load_bri, ack, frame_done
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          bright_req;
    logic          bright_ack;
    logic          sclk;
    logic          latch_enable;
    logic          output_enable_n;
    logic          shift;
    logic          load_led_vals;
    logic          load_brightness;
    logic [NR-1:0] row_select_n;
    logic [0:0]    row_addr;
    logic [PB-1:0] pwm_step;
    logic          frame_done;

    int   cyc    = 0;
    int   base   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;
    logic probe  = 1'b0;
    logic oe_prev = 1'b1;
    ev_t  expq[$];

    led_scan_sequencer #(
        .NUM_ROWS      (NR),
        .PWM_BITS      (PB),
        .SHIFT_LEN     (2),
        .BLANK_CYCLES  (1),
        .DISPLAY_CYCLES(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .bright_req     (bright_req),
        .bright_ack     (bright_ack),
        .sclk           (sclk),
        .latch_enable   (latch_enable),
        .output_enable_n(output_enable_n),
        .shift          (shift),
        .load_led_vals  (load_led_vals),
        .load_brightness(load_brightness),
        .row_select_n   (row_select_n),
        .row_addr       (row_addr),
        .pwm_step       (pwm_step),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Expected event from hand-derived per-kind output values
    task automatic push(input logic [2:0] k, input int c, input logic r, input logic p);
        ev_t e;
        e.kind = k;
        e.cyc  = 32'(c);
        e.row  = r;
        e.pwm  = p;
        e.rsel = 2'b11;
        e.oe_n = 1'b1;
        e.misc = 7'b0000000;
        case (k)
            K_LOAD:  e.misc = 7'b0001000;
            K_BLOAD: e.misc = 7'b0000100;
            K_SHIFT: e.misc = 7'b1010000;
            K_LATCH: begin e.misc = 7'b0100000; e.rsel = r ? 2'b01 : 2'b10; end
            K_ACK:   e.misc = 7'b0100010;
            K_DISP:  begin e.oe_n = 1'b0; e.rsel = r ? 2'b01 : 2'b10; end
            K_FRAME: begin e.oe_n = 1'b0; e.misc = 7'b0000001; e.rsel = r ? 2'b01 : 2'b10; end
            default: ;
        endcase
        expq.push_back(e);
    endtask

    // One display slot starting at cycle s: LOAD s, shift s+2/s+4, LATCH s+6, oe_n low s+7..s+8
    task automatic push_slot(input int s, input logic r, input logic p, input bit last);
        push(K_LOAD, s, r, p);
        push(K_SHIFT, s + 2, r, p);
        push(K_SHIFT, s + 4, r, p);
        push(K_LATCH, s + 6, r, p);
        push(K_DISP, s + 7, r, p);
        if (last) push(K_FRAME, s + 8, r, p);
    endtask

    task automatic push_bslot(input int s);
        push(K_BLOAD, s, 1'b0, 1'b0);
        push(K_SHIFT, s + 2, 1'b0, 1'b0);
        push(K_SHIFT, s + 4, 1'b0, 1'b0);
        push(K_ACK, s + 5, 1'b0, 1'b0);
    endtask

    task automatic wait_rel(input int n);
        while ((cyc - base) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: invariants every cycle, and scoreboard compare on each presented event
    initial forever begin
        ev_t  act;
        ev_t  exp_e;
        logic have;
        @(negedge clk);
        if (mon_en) begin
            n_chk = n_chk + 1;
            if ((latch_enable && !output_enable_n) || ($countones(~row_select_n) > 1)
                || (load_led_vals && load_brightness)) begin
                $display("FAIL invariant at cyc %0d: le=%b oe_n=%b rsel=%b ld=%b lb=%b",
                         cyc - base, latch_enable, output_enable_n, row_select_n,
                         load_led_vals, load_brightness);
            end else begin
                n_pass = n_pass + 1;
            end
            have = 1'b1;
            if (probe)                          act.kind = K_PROBE;
            else if (load_led_vals)             act.kind = K_LOAD;
            else if (load_brightness)           act.kind = K_BLOAD;
            else if (latch_enable)              act.kind = bright_ack ? K_ACK : K_LATCH;
            else if (shift)                     act.kind = K_SHIFT;
            else if (frame_done)                act.kind = K_FRAME;
            else if (!output_enable_n && oe_prev) act.kind = K_DISP;
            else                                have = 1'b0;
            oe_prev = output_enable_n;
            if (have) begin
                act.cyc  = 32'(cyc - base);
                act.row  = row_addr;
                act.pwm  = pwm_step;
                act.rsel = row_select_n;
                act.oe_n = output_enable_n;
                act.misc = {sclk, latch_enable, shift, load_led_vals, load_brightness,
                            bright_ack, frame_done};
                n_chk = n_chk + 1;
                if (expq.size() == 0) begin
                    $display("FAIL unexpected_event: got kind=%0d cyc=%0d, required none",
                             act.kind, act.cyc);
                end else begin
                    exp_e = expq.pop_front();
                    if (act !== exp_e) begin
                        $display("FAIL event_kind%0d: got kind=%0d cyc=%0d row=%b pwm=%b rsel=%b oe_n=%b misc=%b, required kind=%0d cyc=%0d row=%b pwm=%b rsel=%b oe_n=%b misc=%b",
                                 exp_e.kind, act.kind, act.cyc, act.row, act.pwm, act.rsel,
                                 act.oe_n, act.misc, exp_e.kind, exp_e.cyc, exp_e.row,
                                 exp_e.pwm, exp_e.rsel, exp_e.oe_n, exp_e.misc);
                    end else begin
                        n_pass = n_pass + 1;
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        bright_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state, one frame, mid-frame bright_req serviced at frame end, enable drop
        base = cyc;
        push(K_PROBE, 0, 1'b0, 1'b0);
        push_slot(1, 1'b0, 1'b0, 1'b0);
        push_slot(10, 1'b0, 1'b1, 1'b0);
        push_slot(19, 1'b1, 1'b0, 1'b0);
        push_slot(28, 1'b1, 1'b1, 1'b1);
        push_bslot(37);
        push_slot(43, 1'b0, 1'b0, 1'b0);
        push_slot(52, 1'b0, 1'b1, 1'b0);
        push_slot(61, 1'b1, 1'b0, 1'b0);
        push_slot(70, 1'b1, 1'b1, 1'b1);
        push_slot(79, 1'b0, 1'b0, 1'b0);
        push_slot(88, 1'b0, 1'b1, 1'b0);
        push(K_PROBE, 98, 1'b0, 1'b0);
        probe  = 1'b1;
        reset  = 1'b0;
        enable = 1'b1;
        wait_rel(1);
        probe = 1'b0;
        wait_rel(10);
        bright_req = 1'b1;
        wait_rel(42);
        bright_req = 1'b0;
        wait_rel(91);
        enable = 1'b0;
        wait_rel(98);
        probe = 1'b1;
        wait_rel(99);
        probe = 1'b0;

        // Restart from idle at row0/pwm0, then synchronous reset during DISPLAY
        base = cyc;
        push(K_LOAD, 1, 1'b0, 1'b0);
        push(K_SHIFT, 3, 1'b0, 1'b0);
        push(K_SHIFT, 5, 1'b0, 1'b0);
        push(K_LATCH, 7, 1'b0, 1'b0);
        push(K_DISP, 8, 1'b0, 1'b0);
        push(K_PROBE, 9, 1'b0, 1'b0);
        enable = 1'b1;
        wait_rel(8);
        reset  = 1'b1;
        enable = 1'b0;
        wait_rel(9);
        probe = 1'b1;
        wait_rel(10);
        probe = 1'b0;
        reset = 1'b0;
        wait_rel(12);

        // Enable with bright_req pending: brightness first; held req is a new request
        base = cyc;
        push_bslot(1);
        push_slot(7, 1'b0, 1'b0, 1'b0);
        push_slot(16, 1'b0, 1'b1, 1'b0);
        push_slot(25, 1'b1, 1'b0, 1'b0);
        push_slot(34, 1'b1, 1'b1, 1'b1);
        push_bslot(43);
        push(K_PROBE, 50, 1'b0, 1'b0);
        enable     = 1'b1;
        bright_req = 1'b1;
        wait_rel(46);
        enable     = 1'b0;
        bright_req = 1'b0;
        wait_rel(50);
        probe = 1'b1;
        wait_rel(51);
        probe = 1'b0;
        wait_rel(56);

        n_chk = n_chk + 1;
        if (expq.size() != 0) begin
            $display("FAIL drain: got %0d expected events never seen, required 0", expq.size());
        end else begin
            n_pass = n_pass + 1;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
